// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature step decoder: FSM states,
// Gray-code phase values, direction encoding and phase-sequence helpers.
package quad_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Phase code that follows ph in the forward direction.
    function automatic logic [1:0] ph_next_fwd(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_01;
            PH_01:   nxt = PH_11;
            PH_11:   nxt = PH_10;
            PH_10:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

    // Phase code that follows ph in the reverse direction.
    function automatic logic [1:0] ph_next_rev(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_00:   nxt = PH_10;
            PH_10:   nxt = PH_11;
            PH_11:   nxt = PH_01;
            PH_01:   nxt = PH_00;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder phase: flop synchroniser followed by a stability counter that
// only accepts a new level once it has persisted for FILTER_LEN cycles.
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic phase_i,
    output logic filt_o
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign filt_o   = filt_q;

    // Shift chain and stability counter next-state.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], phase_i};
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (synced_s == filt_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = synced_s;
            cnt_d  = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Synchroniser, counter and filtered-level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= 4'd0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters both encoder phases, waits for them to settle,
// then emits one registered up/down pulse per legal Gray-code step.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic CLK,
    input  logic clear,
    input  logic quadA,
    input  logic quadB,
    input  logic enable,
    input  logic errClear,
    output logic up,
    output logic down,
    output logic dir,
    output logic qError
);

    // The extra compare cycle lets the filter output land before prev is captured.
    localparam logic [4:0] SETTLE_LAST = 5'(SYNC_STAGES + FILTER_LEN);

    logic       fa_s, fb_s;
    logic [1:0] phase_s;

    state_e     state_q, state_d;
    logic [4:0] settle_q, settle_d;
    logic [1:0] prev_q, prev_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_a (
        .clk_i   (CLK),
        .rst_i   (clear),
        .phase_i (quadA),
        .filt_o  (fa_s)
    );

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filt_b (
        .clk_i   (CLK),
        .rst_i   (clear),
        .phase_i (quadB),
        .filt_o  (fb_s)
    );

    assign phase_s = {fa_s, fb_s};

    assign up     = up_q;
    assign down   = down_q;
    assign dir    = dir_q;
    assign qError = err_q;

    // Settle sequencing, step classification and output next-state.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        prev_d   = prev_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        dir_d    = dir_q;
        if (errClear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        case (state_q)
            ST_INIT: begin
                if (settle_q == SETTLE_LAST) begin
                    prev_d   = phase_s;
                    settle_d = 5'd0;
                    state_d  = ST_TRACK;
                end else begin
                    settle_d = settle_q + 5'd1;
                end
            end
            ST_TRACK: begin
                if (phase_s == ph_next_fwd(prev_q)) begin
                    dir_d  = DIR_FWD;
                    up_d   = enable;
                    prev_d = phase_s;
                end else if (phase_s == ph_next_rev(prev_q)) begin
                    dir_d  = DIR_REV;
                    down_d = enable;
                    prev_d = phase_s;
                end else if (phase_s != prev_q) begin
                    // Both phases moved together: the error takes priority over errClear.
                    err_d  = 1'b1;
                    prev_d = phase_s;
                end else begin
                    prev_d = prev_q;
                end
            end
            default: begin
                state_d  = ST_INIT;
                settle_d = 5'd0;
            end
        endcase
    end

    // State, settle counter, previous phase and output registers.
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state_q  <= ST_INIT;
            settle_q <= 5'd0;
            prev_q   <= PH_00;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            prev_q   <= prev_d;
            up_q     <= up_d;
            down_q   <= down_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with default parameters; expected
// values are hand-derived from the decoder's timing and step rules.
module tb_quad_step_decoder;

    logic CLK;
    logic clear;
    logic quadA;
    logic quadB;
    logic enable;
    logic errClear;
    logic up;
    logic down;
    logic dir;
    logic qError;

    int checks_r;
    int errors_r;
    int up_tot_r;
    int dn_tot_r;
    int both_tot_r;
    int up0_s;
    int dn0_s;
    int edge_s;

    quad_step_decoder #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .CLK      (CLK),
        .clear    (clear),
        .quadA    (quadA),
        .quadB    (quadB),
        .enable   (enable),
        .errClear (errClear),
        .up       (up),
        .down     (down),
        .dir      (dir),
        .qError   (qError)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge CLK) begin
        if (up === 1'b1) up_tot_r++;
        if (down === 1'b1) dn_tot_r++;
        if (up === 1'b1 && down === 1'b1) both_tot_r++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply AB at a negedge, hold n rising edges, report the edge of the first pulse (0 = none).
    task automatic step_ab(input logic a, input logic b, input int n, output int first_edge);
        @(negedge CLK);
        quadA = a;
        quadB = b;
        first_edge = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            #1;
            if ((up === 1'b1 || down === 1'b1) && first_edge == 0) first_edge = i;
        end
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(negedge CLK);
        clear = 1'b1;
        quadA = a;
        quadB = b;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        clear = 1'b0;
    endtask

    initial begin
        checks_r   = 0;
        errors_r   = 0;
        up_tot_r   = 0;
        dn_tot_r   = 0;
        both_tot_r = 0;
        clear      = 1'b1;
        quadA      = 1'b0;
        quadB      = 1'b0;
        enable     = 1'b1;
        errClear   = 1'b0;

        // Test 1: forward sequence.
        do_reset(1'b0, 1'b0);
        check_val("rst_up", 32'(up), 32'd0);
        check_val("rst_dn", 32'(down), 32'd0);
        check_val("rst_dir", 32'(dir), 32'd0);
        check_val("rst_err", 32'(qError), 32'd0);
        step_ab(1'b0, 1'b0, 10, edge_s);
        check_val("init_nopulse", 32'(edge_s), 32'd0);
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b0, 1'b1, 10, edge_s);
        check_val("fwd_lat_01", 32'(edge_s), 32'd7);
        step_ab(1'b1, 1'b1, 10, edge_s);
        check_val("fwd_lat_11", 32'(edge_s), 32'd7);
        step_ab(1'b1, 1'b0, 10, edge_s);
        check_val("fwd_lat_10", 32'(edge_s), 32'd7);
        step_ab(1'b0, 1'b0, 10, edge_s);
        check_val("fwd_lat_00", 32'(edge_s), 32'd7);
        check_val("fwd_ups", 32'(up_tot_r - up0_s), 32'd4);
        check_val("fwd_downs", 32'(dn_tot_r - dn0_s), 32'd0);
        check_val("fwd_dir", 32'(dir), 32'd1);
        check_val("fwd_err", 32'(qError), 32'd0);

        // Test 2: reverse sequence.
        do_reset(1'b0, 1'b0);
        step_ab(1'b0, 1'b0, 10, edge_s);
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b1, 1'b0, 10, edge_s);
        check_val("rev_lat_10", 32'(edge_s), 32'd7);
        step_ab(1'b1, 1'b1, 10, edge_s);
        step_ab(1'b0, 1'b1, 10, edge_s);
        step_ab(1'b0, 1'b0, 10, edge_s);
        check_val("rev_ups", 32'(up_tot_r - up0_s), 32'd0);
        check_val("rev_downs", 32'(dn_tot_r - dn0_s), 32'd4);
        check_val("rev_dir", 32'(dir), 32'd0);
        check_val("rev_err", 32'(qError), 32'd0);

        // Test 3: glitch rejection, then the shortest accepted pulse (00->10->00).
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b1, 1'b0, 3, edge_s);
        step_ab(1'b0, 1'b0, 10, edge_s);
        check_val("glitch_ups", 32'(up_tot_r - up0_s), 32'd0);
        check_val("glitch_downs", 32'(dn_tot_r - dn0_s), 32'd0);
        step_ab(1'b1, 1'b0, 4, edge_s);
        step_ab(1'b0, 1'b0, 10, edge_s);
        check_val("min_pulse_ups", 32'(up_tot_r - up0_s), 32'd1);
        check_val("min_pulse_downs", 32'(dn_tot_r - dn0_s), 32'd1);
        check_val("min_pulse_dir", 32'(dir), 32'd1);

        // Test 4: double-phase change, errClear, error-wins priority.
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b1, 1'b1, 10, edge_s);
        check_val("dbl_err", 32'(qError), 32'd1);
        check_val("dbl_pulses", 32'((up_tot_r - up0_s) + (dn_tot_r - dn0_s)), 32'd0);
        check_val("dbl_dir", 32'(dir), 32'd1);
        @(negedge CLK);
        errClear = 1'b1;
        @(negedge CLK);
        errClear = 1'b0;
        check_val("errclr", 32'(qError), 32'd0);
        @(negedge CLK);
        quadA = 1'b0;
        quadB = 1'b0;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        errClear = 1'b1;
        @(posedge CLK);
        #1;
        check_val("err_wins", 32'(qError), 32'd1);
        @(negedge CLK);
        errClear = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("err_sticky", 32'(qError), 32'd1);
        check_val("dbl2_dir", 32'(dir), 32'd1);

        // Test 5: power-on with AB=11 gives no pulse or error.
        do_reset(1'b1, 1'b1);
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b1, 1'b1, 12, edge_s);
        check_val("init11_pulses", 32'((up_tot_r - up0_s) + (dn_tot_r - dn0_s)), 32'd0);
        check_val("init11_err", 32'(qError), 32'd0);
        step_ab(1'b1, 1'b0, 10, edge_s);
        check_val("init11_step_lat", 32'(edge_s), 32'd7);
        check_val("init11_step_ups", 32'(up_tot_r - up0_s), 32'd1);
        check_val("init11_step_dir", 32'(dir), 32'd1);

        // Test 6: enable gating, re-enable, asynchronous clear.
        do_reset(1'b0, 1'b0);
        step_ab(1'b0, 1'b0, 10, edge_s);
        enable = 1'b0;
        up0_s = up_tot_r;
        dn0_s = dn_tot_r;
        step_ab(1'b0, 1'b1, 10, edge_s);
        step_ab(1'b1, 1'b1, 10, edge_s);
        check_val("dis_pulses", 32'((up_tot_r - up0_s) + (dn_tot_r - dn0_s)), 32'd0);
        check_val("dis_dir", 32'(dir), 32'd1);
        @(negedge CLK);
        enable = 1'b1;
        step_ab(1'b1, 1'b1, 3, edge_s);
        step_ab(1'b1, 1'b0, 10, edge_s);
        check_val("reen_ups", 32'(up_tot_r - up0_s), 32'd1);
        check_val("reen_downs", 32'(dn_tot_r - dn0_s), 32'd0);
        check_val("reen_err", 32'(qError), 32'd0);
        @(negedge CLK);
        quadA = 1'b0;
        quadB = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        check_val("pre_clr_up", 32'(up), 32'd1);
        check_val("pre_clr_dir", 32'(dir), 32'd1);
        #1;
        clear = 1'b1;
        #1;
        check_val("aclr_up", 32'(up), 32'd0);
        check_val("aclr_dn", 32'(down), 32'd0);
        check_val("aclr_dir", 32'(dir), 32'd0);
        check_val("aclr_err", 32'(qError), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check_val("never_both", 32'(both_tot_r), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
